fifo_ctrl: RTL and testbench
============================

Name: fifo_ctrl

Overview:
- Pointer/flag controller that drives the dual-port FIFO storage array in the convolver line buffers.
- Accepts push/pop requests from the producer (pixel/weight fetch) and consumer (MAC window) stages.
- Produces write/read addresses and enables for the storage array, plus full/empty/almost-full/count status and a read-data-valid strobe aligned to the array's 1-cycle registered read.
- No data path: din goes straight to the storage array; this block owns only addressing and flow control.

Parameters:
- ADDR_W, `ADDR_FIFO, address width of the storage array.
- DEPTH, `DEP_FIFO, number of entries; any value 2..2^ADDR_W, not restricted to powers of two.
- AFULL_TH, DEPTH-2, almost_full asserts when count >= AFULL_TH.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- push  in  1  write request; data is presented on the array din the same cycle.
- pop  in  1  read request.
- mem_we  out  1  write enable to the storage array (combinational).
- mem_waddr  out  ADDR_W  write address (registered pointer).
- mem_re  out  1  read enable to the storage array (combinational).
- mem_raddr  out  ADDR_W  read address (registered pointer).
- rd_valid  out  1  array dout holds popped data this cycle.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AFULL_TH.
- count  out  ADDR_W+1  current occupancy, 0..DEPTH.

Behaviour:
- Reset, asynchronous and active-high:
  - wptr = rptr = 0, count = 0, rd_valid = 0.
  - empty = 1, full = 0, almost_full = 0 (unless AFULL_TH == 0).
  - Reset mid-operation discards all contents; no drain.
- Accept rules:
  - wr_acc = push & (~full | pop).
  - rd_acc = pop & ~empty.
  - mem_we = wr_acc, mem_re = rd_acc; both combinational from inputs and registered state.
- Pointer update:
  - On wr_acc: wptr <= (wptr == DEPTH-1) ? 0 : wptr+1.
  - On rd_acc: rptr is updated with the same wrap rule.
  - mem_waddr = wptr, mem_raddr = rptr.
- Count:
  - wr_acc & ~rd_acc: count+1.
  - rd_acc & ~wr_acc: count-1.
  - Both or neither: unchanged.
- Flags:
  - full, empty and almost_full are registered, computed from next-state count.
  - They are therefore valid in the cycle after the causing event, with no combinational path from push/pop.
- Read latency: rd_valid <= rd_acc. Popped data appears on array dout exactly 1 cycle after the accepted pop, and only while rd_valid = 1.
- Boundary conditions:
  - Push while full without pop: ignored, state unchanged.
  - Pop while empty: ignored, rd_valid = 0 next cycle.
  - Push+pop while empty: only the push is accepted, with no fall-through. count goes to 1 and rd_valid = 0.
  - Push+pop while full: both are accepted, and waddr == raddr in that cycle. The array's read-before-write semantics return the old entry; count stays DEPTH.
  - Wrap-around: a pointer at DEPTH-1 returns to 0. This also applies when DEPTH is not a power of two; addresses >= DEPTH are never issued.
- Throughput: sustained 1 push and 1 pop per cycle.

Optional Feature:
- Macro: FIFO_ERR_FLAG_EN.
- With the macro:
  - Adds outputs overflow and underflow (1 bit each), both sticky.
  - overflow sets on push & full & ~pop.
  - underflow sets on pop & empty.
  - Both clear only on rst.
- Without the macro: the ports and logic are absent, and illegal requests are silently ignored as described in Behaviour.

Decomposition:
- Shared header: ADDR_FIFO, DEP_FIFO and WID_FIFO widths/depths, plus the AFULL threshold default.
- One natural sub-module: fifo_ptr_wrap, a modulo-DEPTH pointer register with increment enable. It is instantiated twice, for wptr and rptr.
- count and flag logic stay in the top level.

Test Plan (DEPTH=8, ADDR_W=3, AFULL_TH=6):
- Reset release, no traffic -> empty=1, full=0, count=0, rd_valid=0, mem_waddr=mem_raddr=0.
- 8 consecutive pushes -> waddr 0..7. almost_full rises the cycle after the 6th push; full=1 and count=8 after the 8th. A 9th push gives mem_we=0 and count stays 8.
- From full, 8 consecutive pops -> raddr 0..7. rd_valid is high for the 8 cycles each lagging its pop by 1. empty=1 after the last; a further pop gives mem_re=0 and rd_valid=0.
- Push+pop in the same cycle while empty -> only the write is accepted, count=1, rd_valid=0 next cycle. Push+pop while full -> waddr==raddr, count stays 8, rd_valid=1.
- 20 cycles of simultaneous push+pop at count=3 -> pointers wrap 7->0 twice, count constant at 3, no address >= 8 is issued.
- Assert rst mid-stream at count=5 -> all outputs return to reset values asynchronously, before the next clk edge. With FIFO_ERR_FLAG_EN, a push while full sets overflow, which stays 1 until rst.

Source files
------------

// File: rtl/fifo_ctrl_pkg.sv
// Shared sizing constants and helpers for the line-buffer FIFO controller.
// Optional sticky error flags are enabled with the FIFO_ERR_FLAG_EN macro.
package fifo_ctrl_pkg;

  // Default storage array geometry.
  localparam int ADDR_FIFO    = 3;
  localparam int DEP_FIFO     = 8;
  localparam int WID_FIFO     = 16;

  // Default almost-full threshold sits this many entries below DEPTH.
  localparam int AFULL_MARGIN = 2;

  // Accepted operation in a cycle, encoded as {write, read}.
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_RD   = 2'b01,
    OP_WR   = 2'b10,
    OP_RW   = 2'b11
  } fifo_op_e;

  function automatic fifo_op_e fifo_op(input logic wr_acc, input logic rd_acc);
    return fifo_op_e'({wr_acc, rd_acc});
  endfunction

endpackage

// File: rtl/fifo_ptr_wrap.sv
// Modulo-DEPTH pointer register with increment enable.
// Wraps from DEPTH-1 to 0, so addresses >= DEPTH are never produced even
// when DEPTH is not a power of two. Unaffected by FIFO_ERR_FLAG_EN.
module fifo_ptr_wrap #(
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_inc,
  output logic [ADDR_W-1:0] o_ptr
);

  localparam logic [ADDR_W-1:0] C_LAST = ADDR_W'(DEPTH - 1);

  logic [ADDR_W-1:0] r_ptr;

  // Advance the pointer on each accepted access, wrapping at DEPTH-1.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    if (rst) begin
      r_ptr <= '0;
    end else if (i_inc) begin
      r_ptr <= (r_ptr == C_LAST) ? '0 : r_ptr + 1'b1;
    end
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/fifo_ctrl.sv
// Pointer/flag controller for the convolver line-buffer FIFO storage array.
// Issues write/read addresses and enables, tracks occupancy, and produces
// registered full/empty/almost-full flags plus a read-data-valid strobe that
// lines up with the array's 1-cycle registered read port.
// Define FIFO_ERR_FLAG_EN to add sticky overflow/underflow outputs.
module fifo_ctrl
  import fifo_ctrl_pkg::*;
#(
  parameter int ADDR_W   = ADDR_FIFO,
  parameter int DEPTH    = DEP_FIFO,
  parameter int AFULL_TH = DEPTH - AFULL_MARGIN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_raddr,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
`ifdef FIFO_ERR_FLAG_EN
  output logic              overflow,
  output logic              underflow,
`endif
  output logic [ADDR_W:0]   count
);

  localparam int              CNT_W       = ADDR_W + 1;
  localparam logic [CNT_W-1:0] C_DEPTH    = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] C_AFULL    = CNT_W'(AFULL_TH);
  localparam logic            C_AFULL_RST = (AFULL_TH == 0);

  logic              w_wr_acc;
  logic              w_rd_acc;
  logic [CNT_W-1:0]  w_count_nxt;
  logic [ADDR_W-1:0] w_wptr;
  logic [ADDR_W-1:0] w_rptr;

  logic [CNT_W-1:0]  r_count;
  logic              r_full;
  logic              r_empty;
  logic              r_afull;
  logic              r_rd_valid;

  // A push into a full FIFO is still accepted when a pop frees the slot in
  // the same cycle; a pop is never accepted from empty, so there is no
  // fall-through of a same-cycle push.
  assign w_wr_acc = push & (~r_full | pop);
  assign w_rd_acc = pop & ~r_empty;

  fifo_ptr_wrap #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_wptr (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_wr_acc),
    .o_ptr (w_wptr)
  );

  fifo_ptr_wrap #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_rptr (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_rd_acc),
    .o_ptr (w_rptr)
  );

  // Next occupancy from the accepted operations this cycle.
  always_comb begin
    // NOTE: default assignment first so every path drives w_count_nxt and
    // no latch is inferred.
    w_count_nxt = r_count;
    unique case (fifo_op(w_wr_acc, w_rd_acc))
      OP_WR:   w_count_nxt = r_count + 1'b1;
      OP_RD:   w_count_nxt = r_count - 1'b1;
      default: w_count_nxt = r_count;
    endcase
  end

  // Occupancy, flags and read-valid; flags come from the next-state count so
  // they are registered with no combinational path from push/pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count    <= '0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_afull    <= C_AFULL_RST;
      r_rd_valid <= 1'b0;
    end else begin
      r_count    <= w_count_nxt;
      r_full     <= (w_count_nxt == C_DEPTH);
      r_empty    <= (w_count_nxt == '0);
      r_afull    <= (w_count_nxt >= C_AFULL);
      r_rd_valid <= w_rd_acc;
    end
  end

`ifdef FIFO_ERR_FLAG_EN
  logic r_overflow;
  logic r_underflow;

  // Sticky error flags for illegal requests; cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (push & r_full & ~pop) r_overflow  <= 1'b1;
      if (pop & r_empty)        r_underflow <= 1'b1;
    end
  end

  assign overflow  = r_overflow;
  assign underflow = r_underflow;
`endif

  assign mem_we      = w_wr_acc;
  assign mem_re      = w_rd_acc;
  assign mem_waddr   = w_wptr;
  assign mem_raddr   = w_rptr;
  assign rd_valid    = r_rd_valid;
  assign full        = r_full;
  assign empty       = r_empty;
  assign almost_full = r_afull;
  assign count       = r_count;

endmodule

// File: tb/tb_fifo_ctrl.sv
// Self-checking bench for fifo_ctrl (DEPTH=8, ADDR_W=3, AFULL_TH=6).
// Models the storage array and checks popped data order against a queue
// scoreboard. Define FIFO_ERR_FLAG_EN to also check overflow/underflow.
module tb_fifo_ctrl;

  localparam int D  = 8;
  localparam int AW = 3;
  localparam int AF = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          push = 1'b0;
  logic          pop = 1'b0;
  logic          mem_we, mem_re, rd_valid, full, empty, almost_full;
  logic [AW-1:0] mem_waddr, mem_raddr;
  logic [AW:0]   count;
`ifdef FIFO_ERR_FLAG_EN
  logic          overflow, underflow;
`endif

  fifo_ctrl #(.ADDR_W(AW), .DEPTH(D), .AFULL_TH(AF)) dut (
    .clk         (clk),
    .rst         (rst),
    .push        (push),
    .pop         (pop),
    .mem_we      (mem_we),
    .mem_waddr   (mem_waddr),
    .mem_re      (mem_re),
    .mem_raddr   (mem_raddr),
    .rd_valid    (rd_valid),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
`ifdef FIFO_ERR_FLAG_EN
    .overflow    (overflow),
    .underflow   (underflow),
`endif
    .count       (count)
  );

  always #5 clk = ~clk;

  // Storage array model: registered read, read-before-write on collision.
  logic [15:0] din = '0;
  logic [15:0] dout;
  logic [15:0] tb_mem [0:D-1];
  always @(posedge clk) begin
    if (mem_re) dout <= tb_mem[mem_raddr];
    if (mem_we) tb_mem[mem_waddr] <= din;
  end

  // Reference model state: occupancy, lifetime access totals, data order.
  int          m_count, m_wr_total, m_rd_total;
  bit          m_rd_valid, m_ovf, m_unf;
  logic [15:0] m_exp_dout, m_next_din;
  logic [15:0] sb [$];

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_count = 0; m_wr_total = 0; m_rd_total = 0;
    m_rd_valid = 0; m_ovf = 0; m_unf = 0;
    sb.delete();
  endtask

  // Apply inputs at the falling edge and let combinational outputs settle.
  task automatic drive(input bit p, input bit q);
    push = p; pop = q; din = m_next_din;
    #1;
  endtask

  task automatic check_data();
    if (m_rd_valid) check("dout", 32'(dout), 32'(m_exp_dout));
  endtask

  // Compare every output against what the model says for the current inputs.
  task automatic model_check();
    bit wr, rd;
    wr = push && (m_count < D || pop);
    rd = pop && m_count > 0;
    check("mem_we",      32'(mem_we),      32'(wr));
    check("mem_re",      32'(mem_re),      32'(rd));
    check("mem_waddr",   32'(mem_waddr),   32'(m_wr_total % D));
    check("mem_raddr",   32'(mem_raddr),   32'(m_rd_total % D));
    check("count",       32'(count),       32'(m_count));
    check("full",        32'(full),        32'(m_count == D));
    check("empty",       32'(empty),       32'(m_count == 0));
    check("almost_full", 32'(almost_full), 32'(m_count >= AF));
    check("rd_valid",    32'(rd_valid),    32'(m_rd_valid));
`ifdef FIFO_ERR_FLAG_EN
    check("overflow",    32'(overflow),    32'(m_ovf));
    check("underflow",   32'(underflow),   32'(m_unf));
`endif
    check_data();
  endtask

  // Update the model for the current inputs, then advance one clock.
  task automatic model_advance();
    bit wr, rd;
    wr = push && (m_count < D || pop);
    rd = pop && m_count > 0;
    if (push && m_count == D && !pop) m_ovf = 1;
    if (pop && m_count == 0) m_unf = 1;
    if (rd) begin m_exp_dout = sb.pop_front(); m_rd_total++; end
    if (wr) begin sb.push_back(din); m_wr_total++; m_next_din = m_next_din + 16'd1; end
    m_count = m_count + int'(wr) - int'(rd);
    m_rd_valid = rd;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic step(input bit p, input bit q);
    drive(p, q);
    model_check();
    model_advance();
  endtask

  typedef struct {
    bit p, q;
    int we, re, waddr, raddr, cnt, fl, em, af, rv;
  } vec_t;
  vec_t tbl [19];

  int wrap_w, wrap_r;

  initial begin
    m_next_din = 16'h0100;
    model_reset();

    // Directed fill / overfill / drain / underpop table.
    for (int i = 0; i < 8; i++)
      tbl[i] = '{1, 0, 1, 0, i, 0, i, 0, int'(i == 0), int'(i >= AF), 0};
    tbl[8] = '{1, 0, 0, 0, 0, 0, 8, 1, 0, 1, 0};
    for (int j = 0; j < 8; j++)
      tbl[9 + j] = '{0, 1, 0, 1, 0, j, 8 - j, int'(j == 0), 0, int'(8 - j >= AF), int'(j > 0)};
    tbl[17] = '{0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1};
    tbl[18] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state with no traffic.
    drive(0, 0);
    check("rst_empty", 32'(empty), 1);
    check("rst_full", 32'(full), 0);
    check("rst_count", 32'(count), 0);
    check("rst_rd_valid", 32'(rd_valid), 0);
    check("rst_waddr", 32'(mem_waddr), 0);
    check("rst_raddr", 32'(mem_raddr), 0);
    model_advance();

    for (int k = 0; k < 19; k++) begin
      drive(tbl[k].p, tbl[k].q);
      check("t_we",    32'(mem_we),      32'(tbl[k].we));
      check("t_re",    32'(mem_re),      32'(tbl[k].re));
      check("t_waddr", 32'(mem_waddr),   32'(tbl[k].waddr));
      check("t_raddr", 32'(mem_raddr),   32'(tbl[k].raddr));
      check("t_count", 32'(count),       32'(tbl[k].cnt));
      check("t_full",  32'(full),        32'(tbl[k].fl));
      check("t_empty", 32'(empty),       32'(tbl[k].em));
      check("t_afull", 32'(almost_full), 32'(tbl[k].af));
      check("t_rdv",   32'(rd_valid),    32'(tbl[k].rv));
      check_data();
      model_advance();
    end

    // Push+pop while empty: write only, no fall-through.
    drive(1, 1);
    check("pe_we", 32'(mem_we), 1);
    check("pe_re", 32'(mem_re), 0);
    model_advance();
    drive(0, 0);
    check("pe_count", 32'(count), 1);
    check("pe_rdv", 32'(rd_valid), 0);
    model_advance();

    // Fill, then push+pop while full: same slot, old data returned.
    repeat (7) step(1, 0);
    drive(1, 1);
    model_check();
    check("pf_waddr", 32'(mem_waddr), 32'(m_rd_total % D));
    check("pf_raddr", 32'(mem_raddr), 32'(m_wr_total % D));
    model_advance();
    drive(0, 0);
    check("pf_count", 32'(count), 8);
    check("pf_rdv", 32'(rd_valid), 1);
    model_check();
    model_advance();

    // Randomized traffic with alternating fill/drain bias.
    for (int i = 0; i < 400; i++) begin
      if (((i / 40) % 2) == 0) step($urandom_range(3, 0) != 0, $urandom_range(3, 0) == 0);
      else                     step($urandom_range(3, 0) == 0, $urandom_range(3, 0) != 0);
    end

    // Asynchronous reset mid-stream at count=5, with rd_valid high.
    drive(0, 0);
    while (m_count > 0) step(0, 1);
    repeat (6) step(1, 0);
    step(0, 1);
    drive(0, 0);
    check("pre_rst_count", 32'(count), 5);
    check("pre_rst_rdv", 32'(rd_valid), 1);
    rst = 1'b1;
    #1;
    check("ar_count", 32'(count), 0);
    check("ar_empty", 32'(empty), 1);
    check("ar_full", 32'(full), 0);
    check("ar_afull", 32'(almost_full), 0);
    check("ar_rdv", 32'(rd_valid), 0);
    check("ar_waddr", 32'(mem_waddr), 0);
    check("ar_raddr", 32'(mem_raddr), 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // Sustained push+pop at count=3 across pointer wrap.
    repeat (3) step(1, 0);
    wrap_w = 0; wrap_r = 0;
    for (int i = 0; i < 20; i++) begin
      drive(1, 1);
      check("ss_waddr_range", 32'(mem_waddr < D), 1);
      check("ss_raddr_range", 32'(mem_raddr < D), 1);
      check("ss_count", 32'(count), 3);
      if (mem_we && mem_waddr == AW'(D - 1)) wrap_w++;
      if (mem_re && mem_raddr == AW'(D - 1)) wrap_r++;
      model_check();
      model_advance();
    end
    check("ss_wrap_w", 32'(wrap_w), 2);
    check("ss_wrap_r", 32'(wrap_r), 2);

`ifdef FIFO_ERR_FLAG_EN
    // Overflow is sticky until reset.
    repeat (5) step(1, 0);
    step(1, 0);
    repeat (3) begin
      drive(0, 0);
      check("ovf_sticky", 32'(overflow), 1);
      model_check();
      model_advance();
    end
    rst = 1'b1;
    #1;
    check("ovf_rst", 32'(overflow), 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    step(0, 1);
    drive(0, 0);
    check("unf_set", 32'(underflow), 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
